// File: rtl/ifd_pkg.sv
// ============================================================================
// ifd_pkg : shared types and helpers for instr_frame_dispatcher
// Rev 1.0
// ============================================================================
`default_nettype none

package ifd_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifd_frame_fifo.sv
// ============================================================================
// ifd_frame_fifo : synchronous FIFO, push accepted when full if a pop coincides
// Rev 1.0
// ============================================================================
`default_nettype none

module ifd_frame_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr;
  logic [AW-1:0]    r_rd;
  logic [AW:0]      r_cnt;
  logic             w_do_pop;
  logic             w_do_push;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign o_data    = r_mem[r_rd];
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/instr_frame_dispatcher.sv
// ============================================================================
// instr_frame_dispatcher : SPI byte -> frame assembler, frame queue, one-hot
// channel dispatch with error/overflow counters. `define CHECKSUM_EN adds a
// trailing XOR byte per frame.                                      Rev 1.0
// ============================================================================
`default_nettype none

module instr_frame_dispatcher
  import ifd_pkg::*;
#(
  parameter int DATA_BYTES     = 8,
  parameter int NUM_CHANNELS   = 4,
  parameter int QUEUE_DEPTH    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int BN_W           = 4
) (
  input  logic                    sysClk,
  input  logic                    sysRst_n,
  input  logic [7:0]              spi_byte,
  input  logic                    spi_input_valid,
  input  logic [BN_W-1:0]         spi_byte_num,
  output logic [7:0]              cmd_instruction,
  output logic [8*DATA_BYTES-1:0] cmd_data,
  output logic [NUM_CHANNELS-1:0] cmd_valid,
  input  logic [NUM_CHANNELS-1:0] cmd_ready,
  output logic [CNT_W-1:0]        frame_err_cnt,
  output logic [CNT_W-1:0]        overflow_cnt,
  output logic                    busy
);

  localparam int CH_W  = clog2_f(NUM_CHANNELS);
  localparam int DW    = 8 * DATA_BYTES;
  localparam int TMO_W = clog2_f(TIMEOUT_CYCLES + 1);
`ifdef CHECKSUM_EN
  localparam int LAST_IDX = DATA_BYTES + 1;
`else
  localparam int LAST_IDX = DATA_BYTES;
`endif
  localparam logic [BN_W-1:0]  LAST_BN = BN_W'(LAST_IDX);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);

  state_t            r_state;
  logic [7:0]        r_instr;
  logic [DW-1:0]     r_data;
  logic [BN_W-1:0]   r_expect;
  logic [TMO_W-1:0]  r_tmo;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [CNT_W-1:0]  r_ovf_cnt;
`ifdef CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic [DW+7:0]     w_head;
  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_idx0;
  logic              w_match;
  logic [CH_W-1:0]   w_sel;

  assign w_idx0  = (spi_byte_num == '0);
  assign w_match = (spi_byte_num == r_expect);

  // A full queue still accepts the frame when the head leaves in the same cycle
  assign w_push = (r_state == ST_COMMIT) && (!w_full || w_pop);

  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      r_state   <= ST_IDLE;
      r_instr   <= '0;
      r_data    <= '0;
      r_expect  <= '0;
      r_tmo     <= '0;
      r_err_cnt <= '0;
      r_ovf_cnt <= '0;
`ifdef CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_COMMIT: begin
          if ((r_state == ST_COMMIT) && !w_push) r_ovf_cnt <= sat_inc(r_ovf_cnt);
          r_state <= ST_IDLE;
          r_tmo   <= '0;
          if (spi_input_valid) begin
            if (w_idx0) begin
              r_instr  <= spi_byte;
              r_expect <= BN_W'(1);
              r_state  <= ST_RECV;
`ifdef CHECKSUM_EN
              r_csum   <= spi_byte;
`endif
            end else begin
              r_err_cnt <= sat_inc(r_err_cnt);
            end
          end
        end

        ST_RECV: begin
          if (spi_input_valid) begin
            r_tmo <= '0;
            if (w_match) begin
`ifdef CHECKSUM_EN
              if (r_expect == LAST_BN) begin
                if (spi_byte == r_csum) begin
                  r_state <= ST_COMMIT;
                end else begin
                  r_err_cnt <= sat_inc(r_err_cnt);
                  r_state   <= ST_IDLE;
                end
              end else begin
                r_data   <= (r_data << 8) | DW'(spi_byte);
                r_csum   <= r_csum ^ spi_byte;
                r_expect <= r_expect + 1'b1;
              end
`else
              r_data   <= (r_data << 8) | DW'(spi_byte);
              r_expect <= r_expect + 1'b1;
              if (r_expect == LAST_BN) r_state <= ST_COMMIT;
`endif
            end else if (w_idx0) begin
              // Restart: the new byte 0 becomes the instruction of a fresh frame
              r_err_cnt <= sat_inc(r_err_cnt);
              r_instr   <= spi_byte;
              r_expect  <= BN_W'(1);
`ifdef CHECKSUM_EN
              r_csum    <= spi_byte;
`endif
            end else begin
              r_err_cnt <= sat_inc(r_err_cnt);
              r_state   <= ST_IDLE;
            end
          end else if (r_tmo == TMO_MAX) begin
            r_err_cnt <= sat_inc(r_err_cnt);
            r_tmo     <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  ifd_frame_fifo #(
    .WIDTH (DW + 8),
    .DEPTH (QUEUE_DEPTH)
  ) u_fifo (
    .clk     (sysClk),
    .rst_n   (sysRst_n),
    .i_push  (w_push),
    .i_data  ({r_instr, r_data}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign cmd_instruction = w_empty ? 8'h00 : w_head[DW+7:DW];
  assign cmd_data        = w_empty ? '0 : w_head[DW-1:0];
  assign w_sel           = cmd_instruction[7 -: CH_W];
  assign cmd_valid       = w_empty ? '0 : (NUM_CHANNELS'(1) << w_sel);
  assign w_pop           = |(cmd_valid & cmd_ready);
  assign frame_err_cnt   = r_err_cnt;
  assign overflow_cnt    = r_ovf_cnt;
  assign busy            = (r_state != ST_IDLE) | ~w_empty;

endmodule

`default_nettype wire
